mem_write_blocked_agen: RTL and testbench
=========================================

Name: mem_write_blocked_agen

Overview:
Next-generation write-address generator for the blocked operand memories that feed the N1-row systolic array. Adds to the previous generation:
- start/busy/done control and a ready/valid input handshake;
- a runtime transpose mode (column-major source);
- configuration validation.
It sits between the operand stream (DMA/AXIS unpacker) and the N1 row-bank memories. It drives a one-hot bank activate plus a shared write address per accepted beat.

Parameters:
N1, 4, number of systolic rows / row-bank memories (>=2)
MATRIXSIZE_W, 16, width of matrix-dimension config inputs and internal counters
ADDR_W, 12, bank write-address width; addresses wrap modulo 2^ADDR_W

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  pulse; latches config and begins a matrix when idle
mode  in  1  0 = row-major layout, 1 = transposed layout; latched at start
M2  in  MATRIXSIZE_W  row pitch for row-major mode
M1dN1  in  MATRIXSIZE_W  phases per block (M1/N1)
BLOCKS  in  MATRIXSIZE_W  number of column blocks
BLOCK_WIDTH  in  MATRIXSIZE_W  columns per block
in_valid  in  1  operand beat present
in_ready  out  1  beat accepted when in_valid && in_ready
wr_en  out  1  registered write strobe
wr_addr  out  ADDR_W  registered write address
activate  out  N1  registered one-hot bank select, valid when wr_en
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse, coincident with the final wr_en
cfg_err  out  1  one-cycle pulse when a start is rejected

Behaviour:
- Reset values: in_ready, wr_en, busy, done, cfg_err = 0; wr_addr = 0; activate = 0; all counters 0.
- States:
  - IDLE: in_ready = 0. On start, if BLOCK_WIDTH, M1dN1 or BLOCKS is 0: cfg_err pulses next cycle and the block stays in IDLE. Otherwise latch all config and mode, then go to RUN.
  - RUN: in_ready = 1; busy = 1.
  - start while busy is ignored, with no cfg_err.
- Counters advance only on an accepted beat, innermost first:
  - col: 0..BLOCK_WIDTH-1
  - row: 0..N1-1
  - phase: 0..M1dN1-1
  - blk: 0..BLOCKS-1
  - Each wraps to 0 and carries to the next counter.
- Address of a beat:
  - mode 0: col + phase*M2 + blk*BLOCK_WIDTH
  - mode 1: col*M1dN1 + phase + blk*BLOCK_WIDTH*M1dN1
  - Built with running accumulators (adders only, no multipliers).
  - Truncated to ADDR_W bits.
- Bank select: activate = one-hot(row), bit 0 = row 0.
- Latency: wr_en, wr_addr and activate are registered one cycle after the accepted beat. wr_en = 0 on cycles with no accepted beat; activate is held at its previous value when wr_en = 0.
- Completion:
  - Final beat = all counters at their maxima (BLOCKS*M1dN1*N1*BLOCK_WIDTH beats total).
  - On accepting it: state returns to IDLE. in_ready drops the following cycle, so no beat beyond the last is accepted.
  - done pulses together with the last wr_en; busy falls in that same cycle.
- Back-pressure: in_valid gaps stall all counters; the address sequence is unchanged.
- Reset mid-operation: all state cleared, no done pulse, and the next start begins fresh.

Optional Feature:
Macro MEM_WRITE_DBUF_EN.
- Defined:
  - Adds output port bank (1 bit, reset 0).
  - bank toggles on each done and is latched per matrix.
  - wr_addr MSB is replaced by bank, giving ping-pong halves; the generated address is wrapped modulo 2^(ADDR_W-1).
- Undefined: no bank port, and full ADDR_W addressing as above.

Decomposition:
- Shared package mem_agen_pkg: state enum (IDLE, RUN) and the mode encoding constants (MODE_ROW = 0, MODE_T = 1).
- One natural sub-module, agen_nested_cnt: a generic 4-level wrap counter with carry outputs and "last" detect. It is reusable by the B-operand and read-side generators.

Test Plan:
1. Row-major, N1=4, BLOCK_WIDTH=2, M1dN1=2, BLOCKS=2, M2=4, continuous valid -> 32 writes.
   - Addresses per row 0,1 with activate 0001, 0010, 0100, 1000.
   - Then 4,5 (x4 banks); then 2,3; then 6,7.
   - done on write 32; busy falls in that cycle.
2. Same config, mode=1 -> address pairs 0,2 | 1,3 | 4,6 | 5,7 (each pair across the 4 banks); activate sequence identical to scenario 1.
3. Scenario 1 with in_valid deasserted every third cycle -> identical address/activate sequence; wr_en gaps match the stalls; one done.
4. start with BLOCKS=0 -> cfg_err pulses once, busy stays 0, no wr_en. A second start during RUN -> ignored, no config change.
5. rst asserted after 10 beats -> all outputs at reset values next cycle, no done; a new start repeats scenario 1 exactly.
6. MEM_WRITE_DBUF_EN, two back-to-back matrices -> first matrix bank=0 with wr_addr MSB 0, second bank=1 with MSB 1; bank=0 after the second done.

Source files
------------

// File: rtl/mem_agen_pkg.sv
// mem_agen_pkg: shared types and constants for the blocked operand
// address generators (write side and the future read / B-operand side).
package mem_agen_pkg;

  // Sequencer state shared by the blocked generators
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } agen_state_e;

  // Source layout encoding carried on the mode input
  localparam logic MODE_ROW = 1'b0;
  localparam logic MODE_T   = 1'b1;

endpackage

// File: rtl/mem_write_blocked_agen_if.sv
// mem_write_blocked_agen_if: operand-stream handshake plus the row-bank
// write bus (strobe, shared address, one-hot bank activate).
// Optional build macro MEM_WRITE_DBUF_EN adds the ping-pong bank select.
// The master side is the address generator, the slave side is the
// operand source / bank memories.
interface mem_write_blocked_agen_if #(
  parameter int N1     = 4,
  parameter int ADDR_W = 12
);

  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [N1-1:0]     activate;

`ifdef MEM_WRITE_DBUF_EN
  logic              bank;

  modport master (
    input  in_valid,
    output in_ready, wr_en, wr_addr, activate, bank
  );

  modport slave (
    output in_valid,
    input  in_ready, wr_en, wr_addr, activate, bank
  );
`else
  modport master (
    input  in_valid,
    output in_ready, wr_en, wr_addr, activate
  );

  modport slave (
    output in_valid,
    input  in_ready, wr_en, wr_addr, activate
  );
`endif

endinterface

// File: rtl/agen_nested_cnt.sv
// agen_nested_cnt: four nested wrap counters (level 0 innermost).
// Each level counts 0..lim-1 and only advances when every level inside
// it wraps. carry[i] is high when level i wraps on this enable, so
// carry[3] marks the final step of the whole nest. last is a pure state
// decode (all levels at their maxima) independent of en.
// Limits of zero are not meaningful; the instantiating block must
// reject them before enabling the count.
module agen_nested_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] lim0,
  input  logic [W-1:0] lim1,
  input  logic [W-1:0] lim2,
  input  logic [W-1:0] lim3,
  output logic [W-1:0] cnt0,
  output logic [W-1:0] cnt1,
  output logic [W-1:0] cnt2,
  output logic [W-1:0] cnt3,
  output logic [3:0]   carry,
  output logic         last
);

  logic [3:0] at_max;

  // Maximum detect per level and the rippled carry chain
  always_comb begin
    at_max[0] = (cnt0 == lim0 - W'(1));
    at_max[1] = (cnt1 == lim1 - W'(1));
    at_max[2] = (cnt2 == lim2 - W'(1));
    at_max[3] = (cnt3 == lim3 - W'(1));
    carry[0]  = en && at_max[0];
    carry[1]  = carry[0] && at_max[1];
    carry[2]  = carry[1] && at_max[2];
    carry[3]  = carry[2] && at_max[3];
    last      = &at_max;
  end

  // Counter registers: clear restarts the nest, en steps the innermost level
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt0 <= '0;
      cnt1 <= '0;
      cnt2 <= '0;
      cnt3 <= '0;
    end else if (en) begin
      cnt0 <= carry[0] ? '0 : cnt0 + W'(1);
      if (carry[0]) begin
        cnt1 <= carry[1] ? '0 : cnt1 + W'(1);
      end
      if (carry[1]) begin
        cnt2 <= carry[2] ? '0 : cnt2 + W'(1);
      end
      if (carry[2]) begin
        cnt3 <= carry[3] ? '0 : cnt3 + W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_write_blocked_agen.sv
// mem_write_blocked_agen: write-address generator for the N1 row-bank
// operand memories of the systolic array.
//
// A start pulse in IDLE latches the matrix geometry and layout mode and
// opens the operand handshake. Every accepted beat produces, one cycle
// later, a write strobe, a shared bank address and a one-hot activate.
// Beats walk col (innermost), row, phase, blk (outermost).
//
// Addresses come from three running accumulators (col, phase, blk terms)
// so no multiplier is needed. The block stride is derived from the column
// term at its maximum plus one column step, which gives BLOCK_WIDTH in
// row-major mode and BLOCK_WIDTH*M1dN1 in transposed mode.
//
// Optional build macro MEM_WRITE_DBUF_EN: adds the bank output, toggled
// at every matrix completion, and substitutes it for the address MSB so
// consecutive matrices land in opposite halves of the memories.
module mem_write_blocked_agen
  import mem_agen_pkg::*;
#(
  parameter int N1           = 4,
  parameter int MATRIXSIZE_W = 16,
  parameter int ADDR_W       = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    mode,
  input  logic [MATRIXSIZE_W-1:0] M2,
  input  logic [MATRIXSIZE_W-1:0] M1dN1,
  input  logic [MATRIXSIZE_W-1:0] BLOCKS,
  input  logic [MATRIXSIZE_W-1:0] BLOCK_WIDTH,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err,
  mem_write_blocked_agen_if.master bus
);

  agen_state_e state;

  logic                    mode_q;
  logic [MATRIXSIZE_W-1:0] m2_q;
  logic [MATRIXSIZE_W-1:0] m1dn1_q;
  logic [MATRIXSIZE_W-1:0] blocks_q;
  logic [MATRIXSIZE_W-1:0] bw_q;

  logic [ADDR_W-1:0] col_acc;
  logic [ADDR_W-1:0] phase_acc;
  logic [ADDR_W-1:0] blk_acc;
  logic [ADDR_W-1:0] stride_col;
  logic [ADDR_W-1:0] stride_phase;
  logic [ADDR_W-1:0] gen_addr;

  logic [MATRIXSIZE_W-1:0] col_cnt;
  logic [MATRIXSIZE_W-1:0] row_cnt;
  logic [MATRIXSIZE_W-1:0] phase_cnt;
  logic [MATRIXSIZE_W-1:0] blk_cnt;
  logic [3:0]              carry;
  logic                    last;

  logic          accept;
  logic          cfg_ok;
  logic          start_ok;
  logic [N1-1:0] act_next;

  // Only the row level drives an output directly; the others exist for
  // their carries, which the accumulators follow.
  logic unused_cnt;
  assign unused_cnt = ^{col_cnt, phase_cnt, blk_cnt};

  assign accept   = bus.in_ready && bus.in_valid;
  assign cfg_ok   = (BLOCK_WIDTH != '0) && (M1dN1 != '0) && (BLOCKS != '0);
  assign start_ok = (state == IDLE) && start && cfg_ok;

  // Per-layout strides of the column and phase accumulators
  always_comb begin
    stride_col   = ADDR_W'(1);
    stride_phase = ADDR_W'(m2_q);
    if (mode_q == MODE_T) begin
      stride_col   = ADDR_W'(m1dn1_q);
      stride_phase = ADDR_W'(1);
    end
  end

  // Address of the beat being accepted this cycle, wrapped by the adder width
  always_comb begin
    gen_addr = col_acc + phase_acc + blk_acc;
  end

  // One-hot bank select decoded from the row counter
  always_comb begin
    act_next = '0;
    for (int i = 0; i < N1; i++) begin
      if (row_cnt == MATRIXSIZE_W'(i)) begin
        act_next[i] = 1'b1;
      end
    end
  end

  agen_nested_cnt #(
    .W (MATRIXSIZE_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_ok),
    .en    (accept),
    .lim0  (bw_q),
    .lim1  (MATRIXSIZE_W'(N1)),
    .lim2  (m1dn1_q),
    .lim3  (blocks_q),
    .cnt0  (col_cnt),
    .cnt1  (row_cnt),
    .cnt2  (phase_cnt),
    .cnt3  (blk_cnt),
    .carry (carry),
    .last  (last)
  );

`ifdef MEM_WRITE_DBUF_EN
  // The bank bit takes the place of the generated MSB.
  logic unused_addr_msb;
  assign unused_addr_msb = gen_addr[ADDR_W-1];
`endif

  // Sequencer, configuration latch, address accumulators and all
  // registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bus.in_ready <= 1'b0;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.activate <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cfg_err      <= 1'b0;
      mode_q       <= MODE_ROW;
      m2_q         <= '0;
      m1dn1_q      <= '0;
      blocks_q     <= '0;
      bw_q         <= '0;
      col_acc      <= '0;
      phase_acc    <= '0;
      blk_acc      <= '0;
`ifdef MEM_WRITE_DBUF_EN
      bus.bank     <= 1'b0;
`endif
    end else begin
      bus.wr_en <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            if (!cfg_ok) begin
              cfg_err <= 1'b1;
            end else begin
              mode_q       <= mode;
              m2_q         <= M2;
              m1dn1_q      <= M1dN1;
              blocks_q     <= BLOCKS;
              bw_q         <= BLOCK_WIDTH;
              col_acc      <= '0;
              phase_acc    <= '0;
              blk_acc      <= '0;
              state        <= RUN;
              bus.in_ready <= 1'b1;
              busy         <= 1'b1;
            end
          end
        end

        RUN: begin
          if (accept) begin
            bus.wr_en    <= 1'b1;
`ifdef MEM_WRITE_DBUF_EN
            bus.wr_addr  <= {bus.bank, gen_addr[ADDR_W-2:0]};
`else
            bus.wr_addr  <= gen_addr;
`endif
            bus.activate <= act_next;

            col_acc <= carry[0] ? '0 : col_acc + stride_col;

            if (carry[2]) begin
              phase_acc <= '0;
            end else if (carry[1]) begin
              phase_acc <= phase_acc + stride_phase;
            end

            if (carry[3]) begin
              blk_acc <= '0;
            end else if (carry[2]) begin
              blk_acc <= blk_acc + col_acc + stride_col;
            end

            if (last) begin
              state        <= IDLE;
              bus.in_ready <= 1'b0;
              busy         <= 1'b0;
              done         <= 1'b1;
`ifdef MEM_WRITE_DBUF_EN
              bus.bank     <= ~bus.bank;
`endif
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_write_blocked_agen.sv
// tb_mem_write_blocked_agen: scoreboard bench for mem_write_blocked_agen.
// Each accepted start pushes the full expected write sequence, computed
// with plain nested loops and the address formulas, into a queue. A
// monitor pops one entry per observed wr_en and also checks that wr_en
// follows every accepted beat by exactly one cycle.
module tb_mem_write_blocked_agen;

  localparam int N1      = 4;
  localparam int MW      = 16;
  localparam int AW      = 12;
  localparam int TIMEOUT = 3000;

  logic          clk    = 1'b0;
  logic          rst    = 1'b1;
  logic          start  = 1'b0;
  logic          mode   = 1'b0;
  logic [MW-1:0] m2     = '0;
  logic [MW-1:0] m1dn1  = '0;
  logic [MW-1:0] blocks = '0;
  logic [MW-1:0] bw     = '0;
  logic          busy;
  logic          done;
  logic          cfg_err;

  mem_write_blocked_agen_if #(.N1(N1), .ADDR_W(AW)) bus ();

  mem_write_blocked_agen #(
    .N1           (N1),
    .MATRIXSIZE_W (MW),
    .ADDR_W       (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mode        (mode),
    .M2          (m2),
    .M1dN1       (m1dn1),
    .BLOCKS      (blocks),
    .BLOCK_WIDTH (bw),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [N1-1:0] act;
    bit            last;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    checks        = 0;
  int    errors        = 0;
  int    wr_count      = 0;
  int    done_count    = 0;
  int    cfg_err_count = 0;
  bit    exp_bank      = 1'b0;
  bit    acc_prev      = 1'b0;
  bit    rst_prev      = 1'b1;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"}, 64'(bus.in_ready), 64'(0));
    checkOutput({tag, "_wr_en"},    64'(bus.wr_en),    64'(0));
    checkOutput({tag, "_wr_addr"},  64'(bus.wr_addr),  64'(0));
    checkOutput({tag, "_activate"}, 64'(bus.activate), 64'(0));
    checkOutput({tag, "_busy"},     64'(busy),         64'(0));
    checkOutput({tag, "_done"},     64'(done),         64'(0));
    checkOutput({tag, "_cfg_err"},  64'(cfg_err),      64'(0));
`ifdef MEM_WRITE_DBUF_EN
    checkOutput({tag, "_bank"},     64'(bus.bank),     64'(0));
`endif
  endtask

  // Reference model: enumerate the matrix in blk/phase/row/col order
  task automatic pushModel(input bit md, input int p_m2, input int p_m1,
                           input int p_blk, input int p_bw);
    beat_t  e;
    longint a;
    for (int b = 0; b < p_blk; b++)
      for (int p = 0; p < p_m1; p++)
        for (int r = 0; r < N1; r++)
          for (int c = 0; c < p_bw; c++) begin
            if (md)
              a = longint'(c) * p_m1 + p + longint'(b) * p_bw * p_m1;
            else
              a = longint'(c) + longint'(p) * p_m2 + longint'(b) * p_bw;
`ifdef MEM_WRITE_DBUF_EN
            e.addr         = AW'(a % (longint'(1) << (AW - 1)));
            e.addr[AW-1]   = exp_bank;
`else
            e.addr         = AW'(a % (longint'(1) << AW));
`endif
            e.act  = N1'(1) << r;
            e.last = (b == p_blk - 1) && (p == p_m1 - 1) &&
                     (r == N1 - 1) && (c == p_bw - 1);
            exp_q.push_back(e);
          end
`ifdef MEM_WRITE_DBUF_EN
    exp_bank = ~exp_bank;
`endif
  endtask

  function automatic logic validFor(input int pattern, input int cyc);
    case (pattern)
      0:       return 1'b1;
      1:       return (cyc % 3) != 2;
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  // Monitor: sampled mid-cycle, pops one expected beat per write strobe
  always @(negedge clk) begin
    checkOutput("wr_en_follows_accept", 64'(bus.wr_en), 64'(acc_prev && !rst_prev));
    if (bus.wr_en) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: wr_addr 0x%0h activate 0x%0h, expected no write",
                 bus.wr_addr, bus.activate);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("wr_addr",  64'(bus.wr_addr),  64'(mon_e.addr));
        checkOutput("activate", 64'(bus.activate), 64'(mon_e.act));
        checkOutput("done_on_write", 64'(done), 64'(mon_e.last));
        if (mon_e.last) checkOutput("busy_at_done", 64'(busy), 64'(0));
      end
    end else if (done) begin
      checkOutput("done_without_write", 64'(done), 64'(0));
    end
    if (done)    done_count++;
    if (cfg_err) cfg_err_count++;
    acc_prev = bus.in_valid && bus.in_ready;
    rst_prev = rst;
  end

  task automatic applyStimulus(input bit md, input int p_m2, input int p_m1,
                               input int p_blk, input int p_bw, input int pattern,
                               input bit mid_start, input int abort_after);
    int cyc;
    int base;
    bit ok;
    ok = (p_m1 != 0) && (p_blk != 0) && (p_bw != 0);
    @(posedge clk); #1;
    mode   = md;
    m2     = MW'(p_m2);
    m1dn1  = MW'(p_m1);
    blocks = MW'(p_blk);
    bw     = MW'(p_bw);
    start  = 1'b1;
    if (ok) pushModel(md, p_m2, p_m1, p_blk, p_bw);
    @(posedge clk); #1;
    start = 1'b0;
    if (!ok) return;
    base = wr_count;
    cyc  = 0;
    bus.in_valid = validFor(pattern, cyc);
    @(negedge clk);
    checkOutput("busy_after_start",     64'(busy),         64'(1));
    checkOutput("in_ready_after_start", 64'(bus.in_ready), 64'(1));
    while (exp_q.size() != 0) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (abort_after != 0 && (wr_count - base) >= abort_after) begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst      = 1'b0;
        exp_q.delete();
        exp_bank = 1'b0;
        return;
      end
      if (cyc > TIMEOUT) begin
        checks++;
        errors++;
        $display("[TB] FAIL timeout: %0d writes pending after %0d cycles, expected 0",
                 exp_q.size(), cyc);
        exp_q.delete();
        break;
      end
      if (mid_start && cyc == 3) begin
        start  = 1'b1;
        mode   = ~md;
        blocks = '0;
        bw     = MW'(p_bw + 1);
      end
      bus.in_valid = validFor(pattern, cyc);
    end
    start        = 1'b0;
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Run one matrix and check completion bookkeeping
  task automatic runMatrix(input string tag, input bit md, input int p_m2, input int p_m1,
                           input int p_blk, input int p_bw, input int pattern,
                           input bit mid_start);
    int d0;
    int c0;
    d0 = done_count;
    c0 = cfg_err_count;
    applyStimulus(md, p_m2, p_m1, p_blk, p_bw, pattern, mid_start, 0);
    checkOutput({tag, "_one_done"},   64'(done_count - d0),    64'(1));
    checkOutput({tag, "_no_cfg_err"}, 64'(cfg_err_count - c0), 64'(0));
    checkOutput({tag, "_idle_busy"},  64'(busy),               64'(0));
`ifdef MEM_WRITE_DBUF_EN
    checkOutput({tag, "_bank"},       64'(bus.bank),           64'(exp_bank));
`endif
  endtask

  initial begin
    int d0;
    int c0;
    int w0;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetValues("reset");
    @(posedge clk); #1 rst = 1'b0;

    $display("[TB] row-major, transposed and stalled runs");
    runMatrix("s1_row",   1'b0, 4, 2, 2, 2, 0, 1'b0);
    runMatrix("s2_trans", 1'b1, 4, 2, 2, 2, 0, 1'b0);
    runMatrix("s3_stall", 1'b0, 4, 2, 2, 2, 1, 1'b0);

    $display("[TB] rejected starts");
    c0 = cfg_err_count;
    w0 = wr_count;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 4, (k == 1) ? 0 : 2, (k == 0) ? 0 : 2, (k == 2) ? 0 : 2, 0, 1'b0, 0);
      bus.in_valid = 1'b1;
      @(negedge clk);
      checkOutput("bad_start_cfg_err",  64'(cfg_err),      64'(1));
      checkOutput("bad_start_busy",     64'(busy),         64'(0));
      checkOutput("bad_start_in_ready", 64'(bus.in_ready), 64'(0));
      @(negedge clk);
      checkOutput("cfg_err_single_cycle", 64'(cfg_err), 64'(0));
    end
    bus.in_valid = 1'b0;
    checkOutput("bad_start_cfg_err_count", 64'(cfg_err_count - c0), 64'(3));
    checkOutput("bad_start_no_writes",     64'(wr_count - w0),      64'(0));

    $display("[TB] start during run is ignored");
    runMatrix("s4_busy_start", 1'b0, 4, 2, 2, 2, 0, 1'b1);

    $display("[TB] reset mid-matrix");
    d0 = done_count;
    applyStimulus(1'b0, 4, 2, 2, 2, 0, 1'b0, 10);
    @(negedge clk);
    checkResetValues("mid_reset");
    repeat (3) @(negedge clk);
    checkOutput("mid_reset_no_done", 64'(done_count - d0), 64'(0));
    runMatrix("s5_restart", 1'b0, 4, 2, 2, 2, 0, 1'b0);

    $display("[TB] address wrap and randomized configurations");
    runMatrix("wrap", 1'b0, 3000, 3, 2, 3, 2, 1'b0);
    for (int k = 0; k < 6; k++) begin
      runMatrix("random", 1'($urandom_range(0, 1)), int'($urandom_range(0, 4095)),
                int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
                int'($urandom_range(1, 3)), 2, 1'b0);
    end

    $display("[TB] back-to-back matrices");
    runMatrix("s6_first",  1'b0, 4, 2, 2, 2, 0, 1'b0);
    runMatrix("s6_second", 1'b0, 4, 2, 2, 2, 0, 1'b0);

    repeat (5) @(negedge clk);
    checkOutput("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
